// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit: operation codes and FSM states.
package shift_pkg;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Single-position shifter: moves the operand by exactly one bit per the mode.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_val
);

  // One-bit move; the fill bit is what distinguishes the four modes.
  always_comb begin
    o_val = i_val;
    case (i_mode)
      MODE_LSL: o_val = {i_val[WIDTH-2:0], 1'b0};
      MODE_LSR: o_val = {1'b0, i_val[WIDTH-1:1]};
      MODE_ASR: o_val = {i_val[WIDTH-1], i_val[WIDTH-1:1]};
      MODE_ROR: o_val = {i_val[0], i_val[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle shift/rotate unit: one bit position per clock, start/busy/done handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_SHIFT | busy; stepping the working register until the count is 0
// ST_DONE  | done pulse, Y just updated; a new start is accepted here
module iterative_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   Y
);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_shift;
  logic [SHAMT_W-1:0] r_cnt;
  logic [1:0]         r_mode;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   w_step;
  logic               w_accept;
  logic               w_cnt_zero;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_val  (r_shift),
    .i_mode (r_mode),
    .o_val  (w_step)
  );

  assign w_cnt_zero = (r_cnt == '0);
  assign Y          = r_y;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state and handshake outputs; DONE accepts start so operations can run back to back.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = start;
        if (start) w_next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (w_cnt_zero) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        w_accept = start;
        w_next_state = start ? ST_SHIFT : ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: capture on accept, step while counting, publish the result as the count expires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_mode  <= MODE_LSL;
      r_y     <= '0;
    end else begin
      if (w_accept) begin
        r_shift <= A;
        r_cnt   <= shamt;
        r_mode  <= mode;
      end else if (r_state == ST_SHIFT && !w_cnt_zero) begin
        r_shift <= w_step;
        r_cnt   <= r_cnt - SHAMT_W'(1);
      end
      if (r_state == ST_SHIFT && w_cnt_zero) r_y <= r_shift;
    end
  end

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Self-checking bench for iterative_shift_unit (WIDTH=8, SHAMT_W=3).
module tb_iterative_shift_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [2:0] shamt;
  logic [1:0] mode;
  logic       busy;
  logic       done;
  logic [7:0] Y;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [2:0] s;
    logic [1:0] m;
    logic [7:0] y;
  } vec_t;

  vec_t tbl[8];

  iterative_shift_unit #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .shamt (shamt),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
    .Y     (Y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: whole shift by s computed directly with arithmetic operators.
  function automatic logic [7:0] ref_y(input logic [7:0] a, input int s, input logic [1:0] m);
    logic [15:0] dbl;
    case (m)
      2'b00: return 8'((16'(a) << s) & 16'hFF);
      2'b01: return 8'(a >> s);
      2'b10: return 8'($signed(a) >>> s);
      default: begin
        dbl = {a, a};
        return 8'(dbl >> s);
      end
    endcase
  endfunction

  // Issue one operation and follow it to completion, checking latency, busy, Y hold and result.
  task automatic do_op(input logic [7:0] a, input logic [2:0] s, input logic [1:0] m,
                       input logic [7:0] exp, input bit pulse_busy, input string name);
    logic [7:0] prev_y;
    int lat;
    @(negedge clk);
    prev_y = Y;
    start = 1'b1; A = a; shamt = s; mode = m;
    @(posedge clk); #1;
    start = 1'b0; A = 8'($urandom); shamt = 3'($urandom); mode = 2'($urandom);
    lat = 0;
    while (!done && lat < 20) begin
      if (busy !== 1'b1 || Y !== prev_y) chk({name, "_busy_hold"}, {busy, Y}, {1'b1, prev_y});
      if (pulse_busy && lat == 2) begin
        start = 1'b1; A = 8'hFF; mode = 2'b11; shamt = 3'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({name, "_done"}, done, 1'b1);
    chk({name, "_latency"}, lat, s + 1);
    chk({name, "_y"}, Y, exp);
    chk({name, "_busy_low"}, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; A = 8'h00; shamt = 3'd0; mode = 2'b00;

    tbl[0] = '{8'hD3, 3'd3, 2'b00, 8'b1001_1000};
    tbl[1] = '{8'hD3, 3'd3, 2'b01, 8'b0001_1010};
    tbl[2] = '{8'hD3, 3'd3, 2'b10, 8'b1111_1010};
    tbl[3] = '{8'hD3, 3'd3, 2'b11, 8'b0111_1010};
    tbl[4] = '{8'h50, 3'd3, 2'b10, 8'b0000_1010};
    tbl[5] = '{8'hD3, 3'd0, 2'b10, 8'b1101_0011};
    tbl[6] = '{8'hD3, 3'd7, 2'b11, 8'b1010_0111};
    tbl[7] = '{8'hD3, 3'd0, 2'b00, 8'b1101_0011};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_y", Y, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].a, tbl[i].s, tbl[i].m, tbl[i].y, 1'b0, $sformatf("vec%0d", i));
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_idle_done", i), done, 1'b0);
    end

    // Start while busy must be ignored.
    do_op(8'hD3, 3'd5, 2'b00, 8'b0110_0000, 1'b1, "ignore_start");

    // Back-to-back: the next op starts in the DONE cycle of the previous one.
    do_op(8'h80, 3'd1, 2'b01, 8'h40, 1'b0, "b2b");
    do_op(8'hD3, 3'd2, 2'b11, 8'hF4, 1'b0, "b2b_2");

    // Reset mid-operation aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; A = 8'hD3; shamt = 3'd6; mode = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_y", Y, 8'h00);
    rst_n = 1'b1;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        if (done) seen = 1'b1;
      end
      chk("abort_no_done", seen, 1'b0);
    end
    do_op(8'hD3, 3'd6, 2'b00, 8'hC0, 1'b0, "after_abort");

    // Randomised operations against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra;
      logic [2:0] rs;
      logic [1:0] rm;
      ra = 8'($urandom);
      rs = 3'($urandom);
      rm = 2'($urandom);
      do_op(ra, rs, rm, ref_y(ra, int'(rs), rm), 1'b0, $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iterative_shift_unit.md
Name: iterative_shift_unit

Overview:
Parametrised, multi-cycle shift/rotate unit. It generalises the 4-bit single-direction logical shifter to any WIDTH, a variable shift amount and four modes. The shift runs one bit position per clock under a start/busy/done handshake, so wide operands need no barrel network. It sits beside the ALU datapath as the shared shift resource.

Parameters:
- WIDTH, 8, operand/result width in bits (must be ≥ 2).
- SHAMT_W, 3, shift-amount width; must equal clog2(WIDTH). Amounts ≥ WIDTH are legal only if SHAMT_W is widened by the integrator.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- A  input  WIDTH  operand; captured on accepted start.
- shamt  input  SHAMT_W  shift amount; captured on accepted start.
- mode  input  2  operation, captured on accepted start:
  - 00 LSL (logical left).
  - 01 LSR (logical right).
  - 10 ASR (arithmetic right, sign-filled).
  - 11 ROR (rotate right).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when Y holds a new result.
- Y  output  WIDTH  result register; holds its value until the next done.

Behaviour:
- One clock domain. Reset is synchronous and active-low (rst_n sampled on the clk rising edge).
- Reset values: state=IDLE, busy=0, done=0, Y=0, internal shift reg=0, counter=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → capture A, shamt and mode into internal registers; go to SHIFT.
  - start=0 → stay in IDLE.
- SHIFT (busy=1):
  - cnt≠0 → shift the internal reg one position per the captured mode; cnt−=1.
  - cnt==0 → Y ← internal reg; go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back operations, no dead cycle); otherwise go to IDLE.
- Latency: done is visible shamt+1 cycles after the edge that accepted start. shamt=0 gives done 1 cycle later with Y=A.
- Per-step rules:
  - LSL: shift left, fill 0.
  - LSR: shift right, fill 0.
  - ASR: shift right, fill with the MSB of the current reg.
  - ROR: shift right, old LSB moves into the MSB.
- start while busy=1 is ignored; no queuing, no error flag.
- Changes to A, shamt or mode after acceptance have no effect on the running operation.
- Y changes only on the cycle done rises. During SHIFT, Y keeps the previous result.
- rst_n=0 mid-operation aborts immediately; all outputs return to reset values on that edge, and no done pulse is produced.
- done and busy are never high in the same cycle.

Decomposition:
- Package shift_pkg holds:
  - mode localparams MODE_LSL=2'b00, MODE_LSR=2'b01, MODE_ASR=2'b10, MODE_ROR=2'b11;
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE.
- One natural sub-module: shift_step. It is a combinational, WIDTH-parametrised single-position shifter (inputs: value and mode; output: value shifted by one). The top level holds only the FSM, the counter and the registers.

Test Plan:
All cases use WIDTH=8, SHAMT_W=3 and A=8'b1101_0011 unless stated.
1. LSL, shamt=3 → done 4 cycles after start; Y=8'b1001_1000. busy high for cycles 1–3 after start. Repeat with LSR, shamt=3 → Y=8'b0001_1010.
2. ASR, shamt=3 → Y=8'b1111_1010. ROR, shamt=3 → Y=8'b0111_1010. Repeat ASR with A=8'b0101_0000 → Y=8'b0000_1010.
3. shamt=0, any mode → done 1 cycle after start; Y=8'b1101_0011. Then shamt=7 with ROR → Y=8'b1010_0111.
4. Start LSL shamt=5. Two cycles later, pulse start with A=8'hFF and change mode/shamt → ignored. Result Y=8'b0110_0000. Y holds the previous result until done.
5. Back-to-back: assert start in the DONE cycle with LSR shamt=1, A=8'h80 → accepted with no idle cycle. Next done gives Y=8'h40.
6. Start LSL shamt=6, then drive rst_n=0 for one cycle during SHIFT → busy=0, done=0, Y=0 on that edge, and no done pulse follows. A fresh start afterwards completes normally.
